// File: rtl/fifo_arb_pkg.sv
// Shared types and the rotate-priority search used by the FIFO write-port arbiter.
// The search works on a fixed 16-wide request vector so one function serves every NUM_REQ.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int MAX_REQ  = 16;
    localparam int MAX_ID_W = 4;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } pick_t;

    // First set bit of req searching upward from last+1, wrapping modulo n.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]  req,
                                      input logic [MAX_ID_W-1:0] last,
                                      input int                  n);
        pick_t r;
        int    i;
        r = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= n && !r.found) begin
                i = (int'(last) + k) % n;
                if (req[i[MAX_ID_W-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = i[MAX_ID_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Combinational rotate-priority encoder: picks the next requester after `last`.
module rr_pick_comb
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last,
    output logic                found,
    output logic [ID_WIDTH-1:0] idx
);

    pick_t pick;

    always_comb begin
        pick = rr_pick(MAX_REQ'(req), MAX_ID_W'(last), NUM_REQ);
    end

    // The range guard is always true for a legal pick; it keeps the full index meaningful.
    assign found = pick.found && ({1'b0, pick.idx} < 5'(NUM_REQ));
    assign idx   = pick.idx[ID_WIDTH-1:0];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ valid/ready requesters,
// granting bursts of up to BURST_LEN beats with one idle cycle between grants.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int BURST_LEN  = 4,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         fifo_full,
    output logic                         fifo_wr_en,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_wdata,
    output logic                         busy,
    output logic [ID_WIDTH-1:0]          grant_id
);

    localparam int              CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [ID_WIDTH-1:0] LAST_REQ = ID_WIDTH'(NUM_REQ - 1);

    arb_state_t            state, state_nxt;
    logic [CNT_W-1:0]      beat_cnt, beat_cnt_nxt;
    logic [ID_WIDTH-1:0]   grant_nxt;
    logic [ID_WIDTH-1:0]   last_grant, last_grant_nxt;
    logic                  pick_found;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic                  gnt_valid;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic                  accept;

    rr_pick_comb #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (req_valid),
        .last  (last_grant),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign gnt_valid = req_valid[grant_id];
    assign gnt_data  = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
    assign accept    = (state == GRANT) && gnt_valid && !fifo_full;
    assign busy      = (state == GRANT);

    always_comb begin
        state_nxt      = state;
        beat_cnt_nxt   = beat_cnt;
        grant_nxt      = grant_id;
        last_grant_nxt = last_grant;
        req_ready      = '0;
        fifo_wr_en     = 1'b0;
        fifo_wdata     = '0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt    = GRANT;
                    grant_nxt    = pick_idx;
                    beat_cnt_nxt = '0;
                end
            end
            GRANT: begin
                req_ready[grant_id] = !fifo_full;
                if (accept) begin
                    fifo_wr_en = 1'b1;
                    fifo_wdata = {grant_id, gnt_data};
                end
                // A bubble from the granted source ends the burst just like a full burst does.
                if (!gnt_valid || (accept && beat_cnt == LAST_BEAT)) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = grant_id;
                    beat_cnt_nxt   = '0;
                end else if (accept) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            grant_id   <= '0;
            last_grant <= LAST_REQ;
        end else begin
            state      <= state_nxt;
            beat_cnt   <= beat_cnt_nxt;
            grant_id   <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios with predicted write schedules,
// randomized traffic checked per source, and a BURST_LEN=1 instance for forced rotation.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int B  = 4;
    localparam int IW = 2;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [IW+DW-1:0]  fifo_wdata;
    logic              busy;
    logic [IW-1:0]     grant_id;

    logic [1:0]        b1_req_valid;
    logic [2*DW-1:0]   b1_req_data;
    logic [1:0]        b1_req_ready;
    logic              b1_fifo_full;
    logic              b1_fifo_wr_en;
    logic [DW:0]       b1_fifo_wdata;
    logic              b1_busy;
    logic [0:0]        b1_grant_id;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(B)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_wdata(fifo_wdata), .busy(busy), .grant_id(grant_id)
    );

    fifo_wr_arbiter #(.NUM_REQ(2), .DATA_WIDTH(DW), .BURST_LEN(1)) dut_b1 (
        .clk(clk), .rst_n(rst_n), .req_valid(b1_req_valid), .req_data(b1_req_data),
        .req_ready(b1_req_ready), .fifo_full(b1_fifo_full), .fifo_wr_en(b1_fifo_wr_en),
        .fifo_wdata(b1_fifo_wdata), .busy(b1_busy), .grant_id(b1_grant_id)
    );

    typedef struct packed {
        int unsigned cyc;
        logic [IW-1:0] tag;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sched[$];
    logic [DW-1:0] word_q[N][$];
    logic [DW-1:0] exp_q[N][$];
    int unsigned   cyc;
    int            checks;
    int            errors;
    bit            rand_mode;
    logic [N-1:0]  acc_s;
    int unsigned   last_wr_cyc;
    int            last_tag;
    int            run_len;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d: got %0h required no event", name, cyc, act);
    endtask

    function automatic int pending_cnt();
        int n = sched.size();
        for (int i = 0; i < N; i++) n += word_q[i].size() + exp_q[i].size();
        return n;
    endfunction

    task automatic queue_word(input int r, input logic [DW-1:0] d);
        word_q[r].push_back(d);
        if (rand_mode) exp_q[r].push_back(d);
    endtask

    task automatic expect_wr(input int unsigned c, input int t, input logic [DW-1:0] d);
        exp_t e;
        e.cyc  = c;
        e.tag  = IW'(t);
        e.data = d;
        sched.push_back(e);
    endtask

    // Advance one cycle and present each requester's head-of-queue word.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (acc_s[i] && word_q[i].size() > 0) void'(word_q[i].pop_front());
            req_valid[i] = (word_q[i].size() > 0);
            req_data[i*DW +: DW] = (word_q[i].size() > 0) ? word_q[i][0] : '0;
        end
    endtask

    task automatic drain(input string name, input int maxc);
        int n = 0;
        while (pending_cnt() > 0 && n < maxc) begin
            step();
            n++;
        end
        check_eq({name, "_drained"}, 64'(pending_cnt()), 64'd0);
        repeat (2) step();
    endtask

    initial begin : monitor
        exp_t          e;
        logic [IW-1:0] tag;
        logic [DW-1:0] d;
        logic [DW-1:0] d_exp;
        forever begin
            @(negedge clk);
            acc_s = '0;
            if (!rst_n) begin
                run_len = 0;
            end else begin
                acc_s = req_valid & req_ready;
                check_eq("ready_onehot", 64'($onehot0(req_ready)), 64'd1);
                if (fifo_full) begin
                    check_eq("ready_under_full", 64'(req_ready), 64'd0);
                    check_eq("wr_en_under_full", 64'(fifo_wr_en), 64'd0);
                end
                check_eq("wr_en_vs_accept", 64'(fifo_wr_en), 64'(|acc_s));
                if (fifo_wr_en) begin
                    tag = fifo_wdata[DW +: IW];
                    d   = fifo_wdata[DW-1:0];
                    if (rand_mode) begin
                        if (exp_q[tag].size() == 0) fail("rand_unexpected_write", 64'(fifo_wdata));
                        else begin
                            d_exp = exp_q[tag].pop_front();
                            check_eq("rand_data", 64'(d), 64'(d_exp));
                        end
                    end else begin
                        if (sched.size() == 0) fail("unexpected_write", 64'(fifo_wdata));
                        else begin
                            e = sched.pop_front();
                            check_eq("wr_cycle", 64'(cyc), 64'(e.cyc));
                            check_eq("wr_tag", 64'(tag), 64'(e.tag));
                            check_eq("wr_data", 64'(d), 64'(e.data));
                        end
                    end
                    if (run_len > 0 && last_wr_cyc == cyc - 1) begin
                        check_eq("burst_same_src", 64'(tag), 64'(last_tag));
                        run_len++;
                        check_eq("burst_len_bound", 64'(run_len <= B), 64'd1);
                    end else begin
                        run_len = 1;
                    end
                    last_wr_cyc = cyc;
                    last_tag    = int'(tag);
                end
            end
        end
    end

    initial begin : stimulus
        logic [DW-1:0] d;
        logic [DW-1:0] dv[6];
        int unsigned   v;
        int            r;
        checks = 0; errors = 0; cyc = 0; rand_mode = 0;
        run_len = 0; last_wr_cyc = 0; last_tag = 0; acc_s = '0;
        rst_n = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0;
        b1_req_valid = '0; b1_req_data = {32'h11, 32'h10}; b1_fifo_full = 1'b0;

        #3;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        check_eq("rst_ready", 64'(req_ready), 64'd0);
        check_eq("rst_wdata", 64'(fifo_wdata), 64'd0);
        check_eq("rst_grant_id", 64'(grant_id), 64'd0);
        #19 rst_n = 1'b1;
        step();
        step();

        // Single requester 2, six words: bursts of four and two split by one idle cycle.
        v = cyc + 1;
        for (int k = 0; k < 6; k++) begin
            d = DW'(32'hA0 + k);
            queue_word(2, d);
            expect_wr(v + 1 + k + k / B, 2, d);
        end
        step();
        #3 check_eq("t2_busy_before_grant", 64'(busy), 64'd0);
        step();
        #3;
        check_eq("t2_busy", 64'(busy), 64'd1);
        check_eq("t2_grant_id", 64'(grant_id), 64'd2);
        drain("t2", 40);

        // All four saturated: full bursts in round-robin order continuing after requester 2.
        v = cyc + 1;
        for (int k = 0; k < 32; k++) begin
            r = (k / B + 3) % N;
            d = $urandom;
            queue_word(r, d);
            expect_wr(v + 1 + k + k / B, r, d);
        end
        drain("t3", 120);

        // Requester 1 stalled by fifo_full for five cycles after two beats.
        v = cyc + 1;
        for (int k = 0; k < 6; k++) begin
            dv[k] = $urandom;
            queue_word(1, dv[k]);
        end
        expect_wr(v + 1, 1, dv[0]);
        expect_wr(v + 2, 1, dv[1]);
        expect_wr(v + 8, 1, dv[2]);
        expect_wr(v + 9, 1, dv[3]);
        expect_wr(v + 11, 1, dv[4]);
        expect_wr(v + 12, 1, dv[5]);
        repeat (4) step();
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            #3;
            check_eq("t4_stall_busy", 64'(busy), 64'd1);
            check_eq("t4_stall_grant", 64'(grant_id), 64'd1);
        end
        step();
        fifo_full = 1'b0;
        drain("t4", 40);

        // Requester 3 sends one beat then drops; pending requester 0 wins after the wrap.
        v = cyc + 1;
        d = $urandom;
        queue_word(3, d);
        expect_wr(v + 1, 3, d);
        dv[0] = $urandom;
        dv[1] = $urandom;
        queue_word(0, dv[0]);
        queue_word(0, dv[1]);
        expect_wr(v + 4, 0, dv[0]);
        expect_wr(v + 5, 0, dv[1]);
        repeat (3) step();
        #3;
        check_eq("t5_bubble_cycle_busy", 64'(busy), 64'd1);
        step();
        #3;
        check_eq("t5_idle_busy", 64'(busy), 64'd0);
        check_eq("t5_idle_grant_hold", 64'(grant_id), 64'd3);
        drain("t5", 40);

        // Asynchronous reset mid-burst: in-flight beat dropped, priority back to requester 0.
        v = cyc + 1;
        for (int k = 0; k < 6; k++) begin
            d = $urandom;
            queue_word(2, d);
            if (k == 0) expect_wr(v + 1, 2, d);
        end
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_busy", 64'(busy), 64'd0);
        check_eq("t6_rst_wr_en", 64'(fifo_wr_en), 64'd0);
        check_eq("t6_rst_ready", 64'(req_ready), 64'd0);
        check_eq("t6_rst_wdata", 64'(fifo_wdata), 64'd0);
        check_eq("t6_rst_grant_id", 64'(grant_id), 64'd0);
        for (int i = 0; i < N; i++) word_q[i].delete();
        req_valid = '0;
        check_eq("t6_first_beat_written", 64'(sched.size()), 64'd0);
        step();
        step();
        #3 rst_n = 1'b1;
        v = cyc + 1;
        for (int k = 0; k < 8; k++) begin
            r = (k < B) ? 1 : 2;
            d = $urandom;
            queue_word(r, d);
            expect_wr(v + 1 + k + k / B, r, d);
        end
        drain("t6", 40);

        // Randomized traffic with random back-pressure, checked per source.
        rand_mode = 1;
        for (int c = 0; c < 600; c++) begin
            step();
            fifo_full = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < N; i++)
                if (word_q[i].size() < 3 && $urandom_range(0, 2) == 0) queue_word(i, $urandom);
        end
        fifo_full = 1'b0;
        drain("rand", 400);
        rand_mode = 0;

        // BURST_LEN=1: two continuously valid requesters alternate with a gap between grants.
        step();
        b1_req_valid = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            step();
            #3;
            check_eq("b1_wr_en", 64'(b1_fifo_wr_en), 64'(k % 2));
            check_eq("b1_busy", 64'(b1_busy), 64'(k % 2));
            if (k % 2 == 1) begin
                check_eq("b1_tag", 64'(b1_fifo_wdata[DW]), 64'(((k - 1) / 2) % 2));
                check_eq("b1_data", 64'(b1_fifo_wdata[DW-1:0]),
                         (((k - 1) / 2) % 2 == 1) ? 64'h11 : 64'h10);
            end
        end
        b1_req_valid = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
